// File: rtl/alu_ctrl_pkg.sv
// Shared opcode values, FSM state encoding and default widths for the ALU front-end controller.
package alu_ctrl_pkg;

  localparam int NB_IN_DEF   = 8;
  localparam int NB_CODE_DEF = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_OP  = 2'b10,
    S_RUN = 2'b11
  } state_t;

  function automatic logic is_legal_op(input logic [5:0] code);
    return (code == OP_ADD) || (code == OP_SUB) || (code == OP_AND) || (code == OP_OR) ||
           (code == OP_XOR) || (code == OP_SRA) || (code == OP_SRL) || (code == OP_NOR);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raw button -> 2-FF sync -> counter debouncer -> one-cycle press pulse on debounced rise.
// Pulse is asserted DB_CYCLES+1 edges after the first edge that samples the raw rise.
module button_debouncer #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [1:0]    sync_q, sync_d;
  logic          db_q, db_d;
  logic          db_prev_q, db_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d    = {sync_q[0], btn};
    db_prev_d = db_q;
    db_d      = db_q;
    cnt_d     = '0;
    // The count must see DB_CYCLES consecutive disagreeing samples; any agreement restarts it.
    if (sync_q[1] != db_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        db_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync_q    <= sync_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      cnt_q     <= cnt_d;
    end
  end

  assign press = db_q & ~db_prev_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Steps the switch bus through operand A, operand B and opcode on debounced enter presses; clear resets.
// Optional macro ALU_OPCODE_CHECK_EN rejects non-ALU opcodes and reports them on o_err.
module alu_operand_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int NB_IN     = NB_IN_DEF,
  parameter int NB_CODE   = NB_CODE_DEF,
  parameter int DB_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NB_IN-1:0]   switch,
  input  logic               b_enter,
  input  logic               b_clear,
  output logic [NB_IN-1:0]   o_dato1,
  output logic [NB_IN-1:0]   o_dato2,
  output logic [NB_CODE-1:0] o_code,
  output logic [1:0]         o_state,
  output logic               o_valid,
  output logic               o_err
);

  logic enter_p, clear_p;

  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_enter (
    .clk(clk), .reset_n(reset_n), .btn(b_enter), .press(enter_p)
  );

  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
    .clk(clk), .reset_n(reset_n), .btn(b_clear), .press(clear_p)
  );

  state_t             state_q, state_d;
  logic [NB_IN-1:0]   dato1_q, dato1_d;
  logic [NB_IN-1:0]   dato2_q, dato2_d;
  logic [NB_CODE-1:0] code_q, code_d;
  logic [NB_CODE-1:0] code_sel;
  logic               err_q, err_d;

  assign code_sel = switch[NB_CODE-1:0];

  always_comb begin
    state_d = state_q;
    dato1_d = dato1_q;
    dato2_d = dato2_q;
    code_d  = code_q;
    err_d   = err_q;
    // Clear takes priority over a coincident enter press.
    if (clear_p) begin
      state_d = S_A;
      dato1_d = '0;
      dato2_d = '0;
      code_d  = '0;
      err_d   = 1'b0;
    end else if (enter_p) begin
      unique case (state_q)
        S_A: begin
          dato1_d = switch;
          state_d = S_B;
          err_d   = 1'b0;
        end
        S_B: begin
          dato2_d = switch;
          state_d = S_OP;
          err_d   = 1'b0;
        end
        S_OP, S_RUN: begin
`ifdef ALU_OPCODE_CHECK_EN
          if (is_legal_op(6'(code_sel))) begin
            code_d  = code_sel;
            state_d = S_RUN;
            err_d   = 1'b0;
          end else begin
            err_d   = 1'b1;
          end
`else
          code_d  = code_sel;
          state_d = S_RUN;
          err_d   = 1'b0;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_A;
      dato1_q <= '0;
      dato2_q <= '0;
      code_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dato1_q <= dato1_d;
      dato2_q <= dato2_d;
      code_q  <= code_d;
      err_q   <= err_d;
    end
  end

  assign o_dato1 = dato1_q;
  assign o_dato2 = dato2_q;
  assign o_code  = code_q;
  assign o_state = state_q;
  assign o_valid = (state_q == S_RUN);
  assign o_err   = err_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with DB_CYCLES=4; expected output changes are queued with their arrival cycle.
module tb_alu_operand_sequencer;

  localparam int DB = 4;

  typedef struct packed {
    logic [1:0] st;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [5:0] code;
    logic       v;
    logic       e;
  } outs_t;

  typedef struct {
    outs_t o;
    int    cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] switch = '0;
  logic       b_enter = 1'b0;
  logic       b_clear = 1'b0;
  logic [7:0] o_dato1, o_dato2;
  logic [5:0] o_code;
  logic [1:0] o_state;
  logic       o_valid, o_err;

  alu_operand_sequencer #(.NB_IN(8), .NB_CODE(6), .DB_CYCLES(DB)) dut (
    .clk(clk), .reset_n(reset_n), .switch(switch), .b_enter(b_enter), .b_clear(b_clear),
    .o_dato1(o_dato1), .o_dato2(o_dato2), .o_code(o_code), .o_state(o_state),
    .o_valid(o_valid), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;
  bit    started = 0;
  outs_t prev = '0;
  outs_t mdl = '0;
  exp_t  q[$];

`ifdef ALU_OPCODE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  function automatic outs_t cur_outs();
    return {o_state, o_dato1, o_dato2, o_code, o_valid, o_err};
  endfunction

  function automatic bit legal(input logic [5:0] c);
    return c == 6'h20 || c == 6'h22 || c == 6'h24 || c == 6'h25 ||
           c == 6'h26 || c == 6'h03 || c == 6'h02 || c == 6'h27;
  endfunction

  function automatic outs_t model(input outs_t c, input bit en, input bit clr, input logic [7:0] sw);
    outs_t r;
    r = c;
    if (clr) begin
      r = '0;
    end else if (en) begin
      case (c.st)
        2'd0: begin r.d1 = sw; r.st = 2'd1; r.e = 1'b0; end
        2'd1: begin r.d2 = sw; r.st = 2'd2; r.e = 1'b0; end
        default: begin
          if (!CHK || legal(sw[5:0])) begin
            r.code = sw[5:0]; r.st = 2'd3; r.v = 1'b1; r.e = 1'b0;
          end else begin
            r.e = 1'b1;
          end
        end
      endcase
    end
    return r;
  endfunction

  // Monitor: every change of the output bundle must match the head of the queue, on the right cycle.
  always @(negedge clk) begin
    outs_t cur;
    exp_t  e;
    if (reset_n && started) begin
      cur = cur_outs();
      if (q.size() > 0 && q[0].cyc < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL late_update: no change by cycle %0d, required %h at cycle %0d", cyc, q[0].o, q[0].cyc);
        void'(q.pop_front());
      end
      if (cur != prev) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: got %h (was %h) at cycle %0d, required no change", cur, prev, cyc);
        end else begin
          e = q.pop_front();
          if (cur !== e.o) begin
            n_fail++;
            $display("FAIL update_value: got %h required %h", cur, e.o);
          end
          n_chk++;
          if (cyc != e.cyc) begin
            n_fail++;
            $display("FAIL update_cycle: got cycle %0d required %0d", cyc, e.cyc);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic press(input logic [7:0] sw, input bit en, input bit clr, input int hold);
    outs_t nxt;
    @(negedge clk);
    switch = sw; b_enter = en; b_clear = clr;
    nxt = model(mdl, en, clr, sw);
    if (nxt != mdl) q.push_back('{nxt, cyc + DB + 3});
    mdl = nxt;
    repeat (hold) @(negedge clk);
    b_enter = 1'b0; b_clear = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      switch = 8'($urandom); b_enter = 1'($urandom); b_clear = 1'($urandom);
    end
    check("rst_state", 32'(o_state), 32'h0);
    check("rst_dato1", 32'(o_dato1), 32'h0);
    check("rst_dato2", 32'(o_dato2), 32'h0);
    check("rst_code",  32'(o_code),  32'h0);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_err",   32'(o_err),   32'h0);
    b_enter = 1'b0; b_clear = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    started = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_outs", 32'(cur_outs()), 32'h0);

    // Bounce shorter than the debounce window
    b_enter = 1'b1; repeat (2) @(negedge clk);
    b_enter = 1'b0; repeat (2) @(negedge clk);
    b_enter = 1'b1; repeat (3) @(negedge clk);
    b_enter = 1'b0; repeat (12) @(negedge clk);
    check("bounce_dato1", 32'(o_dato1), 32'h0);

    press(8'h04, 1, 0, 8);
    press(8'h06, 1, 0, 8);
    press(8'h20, 1, 0, 8);
    press(8'h22, 1, 0, 100);
    press(8'h15, 1, 0, 8);
    press(8'h24, 1, 0, 8);
    press(8'h55, 0, 1, 8);
    press(8'h11, 1, 0, 8);
    press(8'h33, 1, 1, 8);
    check("clr_enter_state", 32'(o_state), 32'h0);

    // Reset during enter debounce: partial count discarded
    @(negedge clk); b_enter = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0; b_enter = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_debounce_state", 32'(o_state), 32'h0);

    repeat (20) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Front-end controller for the ALU board design. It replaces the three separate load buttons with one debounced "enter" button and a "clear" button, stepping a shared switch bus through operand A, operand B and opcode. It then holds the ALU inputs and flags when the ALU output is meaningful. It sits between the board switches/buttons and the ALU operand/opcode inputs.

## Interface
- NB_IN, 8, operand width and switch bus width
- NB_CODE, 6, opcode width
- DB_CYCLES, 1000000, cycles a synchronized button level must differ from the debounced level before it is accepted (≥1)
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- switch  in  NB_IN  shared data/opcode switch bus
- b_enter  in  1  raw enter button, active high, asynchronous to clk
- b_clear  in  1  raw clear button, active high, asynchronous to clk
- o_dato1  out  NB_IN  operand A to ALU
- o_dato2  out  NB_IN  operand B to ALU
- o_code  out  NB_CODE  opcode to ALU
- o_state  out  2  current FSM state, for LEDs
- o_valid  out  1  A, B and opcode all loaded; ALU output meaningful
- o_err  out  1  last opcode press rejected (see Configuration)

## Operation
- Each button path: 2-FF synchronizer, then the debouncer, then a rising-edge detector that gives a 1-cycle press pulse.
- Debouncer: counter clears whenever sync == db. While sync != db the counter increments. When the counter reaches DB_CYCLES, db takes the sync value and the counter clears. Release is debounced the same way.
- FSM states (o_state encoding):
  - S_A=00: enter press → o_dato1<=switch → S_B
  - S_B=01: enter press → o_dato2<=switch → S_OP
  - S_OP=10: enter press → o_code<=switch[NB_CODE-1:0] → S_RUN, o_valid<=1
  - S_RUN=11: enter press → o_code<=switch[NB_CODE-1:0]; stay in S_RUN; operands unchanged (re-run a new op on the same operands)
- Clear press in any state → S_A; o_dato1, o_dato2, o_code, o_valid, o_err <= 0.
- Clear and enter pressed in the same cycle → clear wins; enter is discarded.
- Upper switch bits above NB_CODE are ignored on opcode loads.
- o_valid is 1 only in S_RUN.

## Timing
- Reset values: all outputs 0, state S_A, synchronizers/db/counters 0. Reset may assert mid-debounce; the partial count is discarded.
- Press latency: if the raw rising edge is first sampled at edge 0, db rises at edge DB_CYCLES+1 and outputs/state update at edge DB_CYCLES+2.
- Pulses shorter than DB_CYCLES cycles (bounce) produce no press.
- Holding a button gives exactly one press. The next press needs a debounced release followed by a new debounced assertion.
- Outputs are registered and hold stable between presses; switch changes without a press have no effect.

## Configuration
- ALU_OPCODE_CHECK_EN defined:
  - An opcode press in S_OP/S_RUN is accepted only for ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111.
  - Any other value leaves o_code and state unchanged and sets o_err=1.
  - o_err clears on the next accepted press of any kind, or on clear.
- Undefined: any opcode is latched; o_err tied to 0.

## Structure
- Package alu_ctrl_pkg: the eight opcode localparams, state encoding S_A/S_B/S_OP/S_RUN, default NB_IN/NB_CODE.
- Sub-module button_debouncer (synchronizer + counter + edge pulse, parameter DB_CYCLES), instantiated for b_enter and b_clear. FSM and registers live in the top module.

## Test plan (DB_CYCLES=4)
- Reset asserted with random inputs → all outputs 0, o_state=00. Release reset → outputs unchanged.
- Presses with switch=0x04, 0x06, 0x20 → o_dato1=0x04, o_dato2=0x06, o_code=0x20, o_valid=1, o_state=11. Each update lands exactly 6 edges after the first sampling edge of its press.
- In S_RUN, switch=0x22 then press → o_code=0x22, operands unchanged, o_valid stays 1. Enter held 100 cycles → single update.
- In S_A, enter high for 2 cycles, low, high 3 cycles (bounce) → no state change, o_dato1=0.
- Macro defined, in S_RUN with o_code=0x22: switch=0x15 press → o_code=0x22, o_err=1; then switch=0x24 press → o_code=0x24, o_err=0. Macro undefined, same 0x15 press → o_code=0x15, o_err=0.
- In S_B, enter and clear pressed together → o_state=00, all data 0, o_valid=0. Separately, reset asserted during enter debounce → no press after release.
